// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fb_arbiter
// Purpose  : Single-port framebuffer BRAM arbiter. Display reads always win;
//            camera writes queue in a small FIFO and drain on free cycles.
// Options  : define FB_ARBITER_STATS_EN for stall / high-water statistics.
// Revision : 1.0 - initial release
// ============================================================================
module fb_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rstn,
   input  logic                            i_rd_req,
   input  logic [ADDR_W-1:0]               i_rd_addr,
   output logic [DATA_W-1:0]               o_rd_data,
   output logic                            o_rd_valid,
   input  logic                            i_wr_valid,
   output logic                            o_wr_ready,
   input  logic [ADDR_W-1:0]               i_wr_addr,
   input  logic [DATA_W-1:0]               i_wr_data,
   output logic                            o_mem_en,
   output logic                            o_mem_we,
   output logic [ADDR_W-1:0]               o_mem_addr,
   output logic [DATA_W-1:0]               o_mem_wdata,
   input  logic [DATA_W-1:0]               i_mem_rdata,
   output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
   output logic [15:0]                     o_stall_cnt,
   output logic [$clog2(FIFO_DEPTH):0]     o_max_level
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_LVL_W = c_PTR_W + 1;
   localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(FIFO_DEPTH);

   logic [ADDR_W-1:0]  r_fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0]  r_fifo_data [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_LVL_W-1:0] r_level;
   logic [c_LVL_W-1:0] w_level_nxt;
   logic               r_wr_ready;
   logic               w_push;
   logic               w_pop;
   logic               r_rd_pend;
   logic               r_rd_valid;
   logic [DATA_W-1:0]  r_rd_data;

   assign w_push      = i_wr_valid & r_wr_ready;
   assign w_pop       = ~i_rd_req & (r_level != '0);
   assign w_level_nxt = r_level + c_LVL_W'(w_push) - c_LVL_W'(w_pop);

   // Display reads take the port unconditionally; the FIFO head drains otherwise.
   assign o_mem_en    = i_rd_req | w_pop;
   assign o_mem_we    = w_pop;
   assign o_mem_addr  = i_rd_req ? i_rd_addr : r_fifo_addr[r_rd_ptr];
   assign o_mem_wdata = r_fifo_data[r_rd_ptr];

   assign o_wr_ready   = r_wr_ready;
   assign o_fifo_level = r_level;
   assign o_rd_valid   = r_rd_valid;
   assign o_rd_data    = r_rd_data;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= i_wr_addr;
         r_fifo_data[r_wr_ptr] <= i_wr_data;
      end
   end

   // Ready is registered from the next level so it stays low through reset
   // and a same-cycle pop never re-opens a full FIFO.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_wr_ready <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         r_level    <= w_level_nxt;
         r_wr_ready <= (w_level_nxt != c_FULL);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_rd_pend  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_pend  <= i_rd_req;
         r_rd_valid <= r_rd_pend;
         if (r_rd_pend) r_rd_data <= i_mem_rdata;
      end
   end

`ifdef FB_ARBITER_STATS_EN
   logic [15:0]        r_stall_cnt;
   logic [c_LVL_W-1:0] r_max_level;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_stall_cnt <= '0;
         r_max_level <= '0;
      end else begin
         if (i_wr_valid && !r_wr_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if (w_level_nxt > r_max_level)
            r_max_level <= w_level_nxt;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_max_level = r_max_level;
`else
   assign o_stall_cnt = '0;
   assign o_max_level = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_arbiter
// Purpose  : Scoreboard bench for fb_arbiter with a behavioural 1-cycle BRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

   localparam int ADDR_W     = 17;
   localparam int DATA_W     = 12;
   localparam int FIFO_DEPTH = 4;
   localparam int c_LVL_W    = $clog2(FIFO_DEPTH) + 1;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                rd_req = 1'b0;
   logic [ADDR_W-1:0]   rd_addr = '0;
   logic [DATA_W-1:0]   rd_data;
   logic                rd_valid;
   logic                wr_valid = 1'b0;
   logic                wr_ready;
   logic [ADDR_W-1:0]   wr_addr = '0;
   logic [DATA_W-1:0]   wr_data = '0;
   logic                mem_en, mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata = '0;
   logic [c_LVL_W-1:0]  fifo_level, max_level;
   logic [15:0]         stall_cnt;

   fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
      .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata), .o_fifo_level(fifo_level),
      .o_stall_cnt(stall_cnt), .o_max_level(max_level)
   );

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   function automatic logic [DATA_W-1:0] ref_pix(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(32'h10)) return 12'hABC;
      return a[DATA_W-1:0] ^ 12'h5A5;
   endfunction

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // Scoreboard: expected writes in acceptance order, expected reads with due cycle.
   typedef struct { logic [DATA_W-1:0] d; int due; } rd_exp_t;
   logic [ADDR_W+DATA_W-1:0] wq [$];
   rd_exp_t                  rdq [$];
   int                       m_level = 0;
   bit                       m_ready = 1'b0;
   logic [DATA_W-1:0]        m_last = '0;
   int                       m_stall = 0;
   int                       m_max = 0;

   always @(negedge clk) begin
      rd_exp_t                  r;
      logic [ADDR_W+DATA_W-1:0] w;
      bit                       exp_valid;
      bit                       pop;
      if (!rstn) begin
         m_level = 0; m_ready = 1'b0; m_last = '0; m_stall = 0; m_max = 0;
         wq.delete(); rdq.delete();
         check("rst_ready", 32'(wr_ready), 32'd0);
         check("rst_level", 32'(fifo_level), 32'd0);
         check("rst_rd_valid", 32'(rd_valid), 32'd0);
         check("rst_rd_data", 32'(rd_data), 32'd0);
         check("rst_stall", 32'(stall_cnt), 32'd0);
         check("rst_max", 32'(max_level), 32'd0);
      end else begin
         check("level", 32'(fifo_level), 32'(m_level));
         check("wr_ready", 32'(wr_ready), 32'(m_ready));
         exp_valid = (rdq.size() != 0) && (rdq[0].due == cyc);
         check("rd_valid", 32'(rd_valid), 32'(exp_valid));
         if (exp_valid) begin
            r = rdq.pop_front();
            check("rd_data", 32'(rd_data), 32'(r.d));
            m_last = r.d;
         end else begin
            check("rd_hold", 32'(rd_data), 32'(m_last));
         end
         pop = 1'b0;
         if (rd_req) begin
            check("rd_en", 32'(mem_en), 32'd1);
            check("rd_we", 32'(mem_we), 32'd0);
            check("rd_addr", 32'(mem_addr), 32'(rd_addr));
            rdq.push_back('{d: ref_pix(rd_addr), due: cyc + 2});
         end else if (m_level != 0) begin
            w = wq.pop_front();
            pop = 1'b1;
            check("wr_en", 32'(mem_en), 32'd1);
            check("wr_we", 32'(mem_we), 32'd1);
            check("wr_addr", 32'(mem_addr), 32'(w[ADDR_W+DATA_W-1:DATA_W]));
            check("wr_data", 32'(mem_wdata), 32'(w[DATA_W-1:0]));
         end else begin
            check("idle_en", 32'(mem_en), 32'd0);
            check("idle_we", 32'(mem_we), 32'd0);
         end
`ifdef FB_ARBITER_STATS_EN
         check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
         check("max_level", 32'(max_level), 32'(m_max));
         if (wr_valid && !m_ready && m_stall != 32'hFFFF) m_stall++;
`else
         check("stall_tied", 32'(stall_cnt), 32'd0);
         check("max_tied", 32'(max_level), 32'd0);
`endif
         if (wr_valid && m_ready) begin
            wq.push_back({wr_addr, wr_data});
            m_level++;
         end
         if (pop) m_level--;
         if (m_level > m_max) m_max = m_level;
         m_ready = (m_level != FIFO_DEPTH);
      end
   end

   int beat = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // rd_mode / wr_mode: 0 off, 1 on, 2 random.
   task automatic run(input int n, input int rd_mode, input int wr_mode);
      bit acc;
      for (int i = 0; i < n; i++) begin
         rd_req   = (rd_mode == 2) ? 1'($urandom_range(0, 1)) : (rd_mode == 1);
         rd_addr  = ADDR_W'(32'h200 + $urandom_range(0, 255));
         wr_valid = (wr_mode == 2) ? 1'($urandom_range(0, 1)) : (wr_mode == 1);
         wr_addr  = ADDR_W'(32'h100 + beat);
         wr_data  = DATA_W'(beat * 37 + 5);
         acc = wr_valid && wr_ready;
         step();
         if (acc) beat++;
      end
      rd_req = 1'b0; wr_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((m_level != 0 || rdq.size() != 0) && n < 50) begin
         step();
         n++;
      end
      check("drain_wq", 32'(wq.size()), 32'd0);
      check("drain_rdq", 32'(rdq.size()), 32'd0);
   endtask

   initial begin
      for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = ref_pix(ADDR_W'(a));
      rstn = 1'b0;
      repeat (3) step();
      rstn = 1'b1;
      run(2, 0, 0);

      rd_req = 1'b1; rd_addr = ADDR_W'(32'h10);
      step();
      rd_req = 1'b0;
      run(3, 0, 0);

      wr_valid = 1'b1; wr_addr = ADDR_W'(32'h5); wr_data = 12'h123;
      step();
      wr_valid = 1'b0;
      run(3, 0, 0);

      run(10, 1, 1);
      run(8, 0, 0);
      drain();

      run(60, 2, 2);
      drain();

      run(3, 1, 1);
      rd_req = 1'b1;
      rstn = 1'b0;
      step();
      rd_req = 1'b0;
      step();
      rstn = 1'b1;
      run(5, 0, 0);
      run(6, 0, 1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
